// File: rtl/frontend_fetch_bp.sv
// Fetch frontend: one aligned block per ICache access, direct-mapped BTB,
// epoch-style discard of stale responses on flush, registered output.
module frontend_fetch_bp #(
  parameter int          IF_WIDTH    = 4,
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h1eceb000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [31:0]            redirect_pc,
  input  logic                   upd_valid,
  input  logic [31:0]            upd_pc,
  input  logic [31:0]            upd_target,
  input  logic                   upd_taken,
  output logic                   ic_req_valid,
  output logic [31:0]            ic_req_addr,
  input  logic                   ic_req_ready,
  input  logic                   ic_resp_valid,
  input  logic [IF_WIDTH*32-1:0] ic_resp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [IF_WIDTH*32-1:0] out_inst,
  output logic [IF_WIDTH-1:0]    out_slot_valid,
  output logic [IF_WIDTH-1:0]    out_pred_taken,
  output logic [IF_WIDTH*32-1:0] out_pred_target
);

  localparam int BLK     = IF_WIDTH * 4;
  localparam int BTB_IDX = $clog2(BTB_ENTRIES);
  localparam int TAG_W   = 32 - BTB_IDX - 2;
  localparam logic [31:0] BLK_MASK = ~(32'(BLK) - 32'd1);

  typedef enum logic {
    S_REQ,
    S_WAIT
  } state_e;

  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic discard_q, discard_d;

  logic                   out_valid_q, out_valid_d;
  logic [31:0]            out_pc_q, out_pc_d;
  logic [IF_WIDTH*32-1:0] out_inst_q, out_inst_d;
  logic [IF_WIDTH-1:0]    slot_v_q, slot_v_d;
  logic [IF_WIDTH-1:0]    pred_tk_q, pred_tk_d;
  logic [IF_WIDTH*32-1:0] pred_tg_q, pred_tg_d;

  logic [BTB_ENTRIES-1:0] btb_v_q, btb_v_d;
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0]       btb_tag_d [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q [BTB_ENTRIES];
  logic [31:0]            btb_tgt_d [BTB_ENTRIES];

  logic [31:0]            aligned_pc;
  logic [31:0]            slot_off;
  logic [31:0]            next_pc;
  logic [IF_WIDTH-1:0]    sv;
  logic [IF_WIDTH-1:0]    pt;
  logic [IF_WIDTH*32-1:0] ptg;
  logic [31:0]            p;
  logic [BTB_IDX-1:0]     lidx;
  logic                   hit;
  logic                   blocked;
  logic                   capture;
  logic [BTB_IDX-1:0]     uidx;

  assign aligned_pc = pc_q & BLK_MASK;
  assign slot_off   = (pc_q >> 2) & 32'(IF_WIDTH - 1);

  // Slots left of the entry point and behind a predicted-taken slot are dead.
  always_comb begin
    sv      = '0;
    pt      = '0;
    ptg     = '0;
    p       = '0;
    lidx    = '0;
    hit     = 1'b0;
    blocked = 1'b0;
    next_pc = aligned_pc + 32'(BLK);
    for (int i = 0; i < IF_WIDTH; i++) begin
      p     = aligned_pc + 32'(4 * i);
      lidx  = p[BTB_IDX+1:2];
      hit   = btb_v_q[lidx] &&
              (btb_tag_q[lidx] == p[31:BTB_IDX+2]);
      sv[i] = (32'(i) >= slot_off) && !blocked;
      pt[i] = hit && sv[i];
      ptg[32*i +: 32] = pt[i] ? btb_tgt_q[lidx] : p + 32'd4;
      if (pt[i] && !blocked) next_pc = btb_tgt_q[lidx];
      blocked = blocked | pt[i];
    end
  end

  assign uidx = upd_pc[BTB_IDX+1:2];

  always_comb begin
    btb_v_d   = btb_v_q;
    btb_tag_d = btb_tag_q;
    btb_tgt_d = btb_tgt_q;
    if (upd_valid) begin
      if (upd_taken) begin
        btb_v_d[uidx]   = 1'b1;
        btb_tag_d[uidx] = upd_pc[31:BTB_IDX+2];
        btb_tgt_d[uidx] = upd_target;
      end else if (btb_tag_q[uidx] == upd_pc[31:BTB_IDX+2]) begin
        btb_v_d[uidx] = 1'b0;
      end
    end
  end

  assign ic_req_valid = rst_n && (state_q == S_REQ) && !flush &&
                        (!out_valid_q || out_ready);
  assign ic_req_addr  = aligned_pc;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    out_valid_d = out_valid_q && !out_ready;
    capture     = 1'b0;
    if (flush) begin
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      // A response landing in the flush cycle retires the outstanding request.
      if (state_q == S_WAIT && !ic_resp_valid) begin
        state_d   = S_WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = S_REQ;
        discard_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (ic_req_valid && ic_req_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (ic_resp_valid) begin
            state_d = S_REQ;
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              capture     = 1'b1;
              out_valid_d = 1'b1;
              pc_d        = next_pc;
            end
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    slot_v_d   = slot_v_q;
    pred_tk_d  = pred_tk_q;
    pred_tg_d  = pred_tg_q;
    if (capture) begin
      out_pc_d   = pc_q;
      out_inst_d = ic_resp_data;
      slot_v_d   = sv;
      pred_tk_d  = pt;
      pred_tg_d  = ptg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      slot_v_q    <= '0;
      pred_tk_q   <= '0;
      pred_tg_q   <= '0;
      btb_v_q     <= '0;
      btb_tag_q   <= '{default: '0};
      btb_tgt_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      slot_v_q    <= slot_v_d;
      pred_tk_q   <= pred_tk_d;
      pred_tg_q   <= pred_tg_d;
      btb_v_q     <= btb_v_d;
      btb_tag_q   <= btb_tag_d;
      btb_tgt_q   <= btb_tgt_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_pc          = out_pc_q;
  assign out_inst        = out_inst_q;
  assign out_slot_valid  = slot_v_q;
  assign out_pred_taken  = pred_tk_q;
  assign out_pred_target = pred_tg_q;

endmodule

// File: tb/tb_frontend_fetch_bp.sv
// Directed bench for frontend_fetch_bp with a small ICache responder
// whose instruction words equal their own addresses.
module tb_frontend_fetch_bp;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic [31:0]    redirect_pc;
  logic           upd_valid;
  logic [31:0]    upd_pc;
  logic [31:0]    upd_target;
  logic           upd_taken;
  logic           ic_req_valid;
  logic [31:0]    ic_req_addr;
  logic           ic_req_ready;
  logic           ic_resp_valid;
  logic [W*32-1:0] ic_resp_data;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_pc;
  logic [W*32-1:0] out_inst;
  logic [W-1:0]   out_slot_valid;
  logic [W-1:0]   out_pred_taken;
  logic [W*32-1:0] out_pred_target;

  int tests = 0;
  int fails = 0;
  int lat = 1;
  int cnt = 0;
  logic pending = 1'b0;
  logic [31:0] raddr = '0;
  logic [31:0] hold_pc;
  logic [31:0] hold_i0;

  frontend_fetch_bp #(
    .IF_WIDTH(W),
    .BTB_ENTRIES(16),
    .RESET_PC(32'h1eceb000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .redirect_pc(redirect_pc),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_target(upd_target),
    .upd_taken(upd_taken),
    .ic_req_valid(ic_req_valid),
    .ic_req_addr(ic_req_addr),
    .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid),
    .ic_resp_data(ic_resp_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .out_slot_valid(out_slot_valid),
    .out_pred_taken(out_pred_taken),
    .out_pred_target(out_pred_target)
  );

  always #5 clk = ~clk;

  function automatic logic [W*32-1:0] blk(input logic [31:0] a);
    logic [W*32-1:0] d;
    for (int i = 0; i < W; i++) d[32*i +: 32] = a + 32'(4 * i);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; advances one clock and runs the ICache model.
  task automatic step();
    logic hs;
    logic [31:0] a;
    #1;
    hs = ic_req_valid && ic_req_ready;
    a  = ic_req_addr;
    @(posedge clk);
    @(negedge clk);
    if (ic_resp_valid) begin
      ic_resp_valid = 1'b0;
      pending = 1'b0;
    end
    if (hs) begin
      pending = 1'b1;
      cnt = lat;
      raddr = a;
    end else if (pending) begin
      cnt--;
    end
    if (pending && cnt == 1) begin
      ic_resp_valid = 1'b1;
      ic_resp_data = blk(raddr);
    end
  endtask

  task automatic fetch_pkt(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < 20);
    chk(tag, {127'd0, out_valid}, 128'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    redirect_pc = '0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_target = '0;
    upd_taken = 1'b0;
    ic_req_ready = 1'b1;
    ic_resp_valid = 1'b0;
    ic_resp_data = '0;
    out_ready = 1'b1;

    #1;
    chk("rst_req_valid", {127'd0, ic_req_valid}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_slot_valid", {124'd0, out_slot_valid}, 128'd0);
    chk("rst_out_pc", {96'd0, out_pc}, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t1_req_valid", {127'd0, ic_req_valid}, 128'd1);
    chk("t1_req_addr", {96'd0, ic_req_addr}, {96'd0, 32'h1eceb000});
    fetch_pkt("t1_pkt");
    chk("t1_out_pc", {96'd0, out_pc}, {96'd0, 32'h1eceb000});
    chk("t1_slot_valid", {124'd0, out_slot_valid}, {124'd0, 4'b1111});
    chk("t1_pred_taken", {124'd0, out_pred_taken}, 128'd0);
    chk("t1_inst", out_inst, blk(32'h1eceb000));
    chk("t1_tgt3", {96'd0, out_pred_target[127:96]},
        {96'd0, 32'h1eceb010});
    #1;
    chk("t1_next_addr", {96'd0, ic_req_addr}, {96'd0, 32'h1eceb010});

    flush = 1'b1;
    redirect_pc = 32'h1eceb008;
    #1;
    chk("t2_flush_req", {127'd0, ic_req_valid}, 128'd0);
    step();
    flush = 1'b0;
    #1;
    chk("t2_out_cleared", {127'd0, out_valid}, 128'd0);
    chk("t2_req_addr", {96'd0, ic_req_addr}, {96'd0, 32'h1eceb000});
    fetch_pkt("t2_pkt");
    chk("t2_out_pc", {96'd0, out_pc}, {96'd0, 32'h1eceb008});
    chk("t2_slot_valid", {124'd0, out_slot_valid}, {124'd0, 4'b1100});
    #1;
    chk("t2_next_addr", {96'd0, ic_req_addr}, {96'd0, 32'h1eceb010});

    flush = 1'b1;
    redirect_pc = 32'h1eceb000;
    upd_valid = 1'b1;
    upd_pc = 32'h1eceb004;
    upd_target = 32'h1eceb100;
    upd_taken = 1'b1;
    step();
    flush = 1'b0;
    upd_pc = 32'h1eceb044;
    upd_taken = 1'b0;
    step();
    upd_valid = 1'b0;
    fetch_pkt("t3_pkt");
    chk("t3_pred_taken", {124'd0, out_pred_taken}, {124'd0, 4'b0010});
    chk("t3_slot_valid", {124'd0, out_slot_valid}, {124'd0, 4'b0011});
    chk("t3_tgt1", {96'd0, out_pred_target[63:32]},
        {96'd0, 32'h1eceb100});
    chk("t3_tgt0", {96'd0, out_pred_target[31:0]},
        {96'd0, 32'h1eceb004});
    #1;
    chk("t3_next_addr", {96'd0, ic_req_addr}, {96'd0, 32'h1eceb100});

    flush = 1'b1;
    redirect_pc = 32'h1eceb000;
    upd_valid = 1'b1;
    upd_pc = 32'h1eceb004;
    upd_taken = 1'b0;
    step();
    flush = 1'b0;
    upd_valid = 1'b0;
    fetch_pkt("t3b_pkt");
    chk("t3b_pred_taken", {124'd0, out_pred_taken}, 128'd0);
    chk("t3b_slot_valid", {124'd0, out_slot_valid}, {124'd0, 4'b1111});
    #1;
    chk("t3b_next_addr", {96'd0, ic_req_addr}, {96'd0, 32'h1eceb010});

    lat = 3;
    step();
    chk("t4_in_wait", {127'd0, ic_req_valid}, 128'd0);
    flush = 1'b1;
    redirect_pc = 32'h1eceb020;
    step();
    flush = 1'b0;
    fetch_pkt("t4_pkt");
    chk("t4_out_pc", {96'd0, out_pc}, {96'd0, 32'h1eceb020});
    chk("t4_inst0", {96'd0, out_inst[31:0]}, {96'd0, 32'h1eceb020});
    lat = 1;

    out_ready = 1'b0;
    #1;
    chk("t5_req_blocked", {127'd0, ic_req_valid}, 128'd0);
    hold_pc = out_pc;
    hold_i0 = out_inst[31:0];
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_hold_valid", {127'd0, out_valid}, 128'd1);
      chk("t5_hold_pc", {96'd0, out_pc}, {96'd0, hold_pc});
      chk("t5_hold_inst", {96'd0, out_inst[31:0]}, {96'd0, hold_i0});
      chk("t5_hold_req", {127'd0, ic_req_valid}, 128'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("t5_release_req", {127'd0, ic_req_valid}, 128'd1);
    chk("t5_release_addr", {96'd0, ic_req_addr}, {96'd0, 32'h1eceb030});
    fetch_pkt("t5_pkt");
    chk("t5_out_pc", {96'd0, out_pc}, {96'd0, 32'h1eceb030});

    flush = 1'b1;
    redirect_pc = 32'hfffffff0;
    upd_valid = 1'b1;
    upd_pc = 32'h1eceb008;
    upd_target = 32'h1eceb200;
    upd_taken = 1'b1;
    step();
    flush = 1'b0;
    upd_valid = 1'b0;
    fetch_pkt("t6_pkt");
    chk("t6_out_pc", {96'd0, out_pc}, {96'd0, 32'hfffffff0});
    chk("t6_slot_valid", {124'd0, out_slot_valid}, {124'd0, 4'b1111});
    chk("t6_tgt3", {96'd0, out_pred_target[127:96]}, 128'd0);
    #1;
    chk("t6_wrap_addr", {96'd0, ic_req_addr}, 128'd0);

    step();
    chk("t7_in_wait", {127'd0, ic_req_valid}, 128'd0);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_req", {127'd0, ic_req_valid}, 128'd0);
    chk("t7_rst_valid", {127'd0, out_valid}, 128'd0);
    chk("t7_rst_slot", {124'd0, out_slot_valid}, 128'd0);
    chk("t7_rst_pc", {96'd0, out_pc}, 128'd0);
    ic_resp_valid = 1'b0;
    pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t7_req_addr", {96'd0, ic_req_addr}, {96'd0, 32'h1eceb000});
    fetch_pkt("t7_pkt");
    chk("t7_pred_taken", {124'd0, out_pred_taken}, 128'd0);
    chk("t7_slot_valid", {124'd0, out_slot_valid}, {124'd0, 4'b1111});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frontend_fetch_bp.md
Name: frontend_fetch_bp

Overview:
- Parametrised fetch frontend: fetches one aligned IF_WIDTH-instruction block per ICache access and produces a packet for the instruction FIFO.
- Adds over the current fetch stage: per-slot valid masking for unaligned redirects, a direct-mapped BTB for taken-branch prediction, an epoch-based drop of stale ICache responses on flush, and a registered output with backpressure.
- Sits between the backend flush/redirect and BTB update ports, the ICache request/response port, and the frontend FIFO.

Parameters:
- IF_WIDTH, 4: instructions per fetch block; power of 2, range 1..8. IF_BLK_SIZE = IF_WIDTH*4 bytes.
- BTB_ENTRIES, 16: BTB depth; power of 2, at least 2. BTB_IDX = log2(BTB_ENTRIES).
- RESET_PC, 32'h1eceb000: first fetch address after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  backend redirect request
- redirect_pc  in  32  redirect target, word aligned
- upd_valid  in  1  BTB update strobe
- upd_pc  in  32  resolved branch PC
- upd_target  in  32  resolved target
- upd_taken  in  1  resolved direction
- ic_req_valid  out  1  ICache request
- ic_req_addr  out  32  block-aligned address
- ic_req_ready  in  1  ICache accepts request
- ic_resp_valid  in  1  response strobe, one per accepted request, no backpressure
- ic_resp_data  in  IF_WIDTH*32  block, slot i = bits [32i+31:32i]
- out_valid  out  1  packet valid
- out_ready  in  1  FIFO ready
- out_pc  out  32  fetch PC (unaligned after a redirect)
- out_inst  out  IF_WIDTH*32  instructions
- out_slot_valid  out  IF_WIDTH  per-slot valid mask
- out_pred_taken  out  IF_WIDTH  per-slot predicted taken
- out_pred_target  out  IF_WIDTH*32  per-slot predicted next PC

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; FSM=REQ; discard=0; out_valid=0; all BTB valid bits=0; all other outputs 0. ic_req_valid=0 during reset.
- FSM state REQ:
  - ic_req_valid=1 when out_valid=0, or when out_valid&&out_ready in the same cycle; ic_req_addr = pc & ~(IF_BLK_SIZE-1).
  - On handshake (ic_req_valid && ic_req_ready): move to WAIT.
  - At most one request is outstanding at any time.
- FSM state WAIT, on ic_resp_valid:
  - discard=1: clear discard, drop the data, go to REQ (pc already redirected).
  - discard=0: register the packet; out_valid=1; pc=next_pc; go to REQ.
- Slot math:
  - slot PC p_i = aligned_pc + 4i.
  - Slot i valid iff i >= pc[log2(IF_BLK_SIZE)-1:2] AND no lower valid slot is predicted taken.
- BTB entry: valid, tag = p[31:BTB_IDX+2], target.
  - Slot hits when entry[p_i[BTB_IDX+1:2]] is valid with a matching tag; a hit predicts taken.
  - out_pred_taken[i] = hit && slot valid.
  - out_pred_target[i] = BTB target if pred_taken[i], else p_i+4.
  - next_pc = target of the lowest valid taken slot; otherwise aligned_pc + IF_BLK_SIZE, wrapping mod 2^32.
- BTB update (upd_valid):
  - upd_taken=1: write valid/tag/target at the upd_pc index (overwrite).
  - upd_taken=0: clear valid if the tag matches; no change otherwise.
  - A lookup in the same cycle as a write sees the old contents.
- Output:
  - Packet registers hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new response is captured in the same cycle.
  - out_valid=1 implies at least one slot is valid.
- Flush (highest priority, any state):
  - pc=redirect_pc; out_valid=0; FSM=REQ.
  - If a request is outstanding, or a request handshakes in the flush cycle: discard=1 and FSM=WAIT; otherwise discard=0.
  - ic_req_valid=0 during the flush cycle.
  - A response arriving in the flush cycle is dropped, and discard is not set for it.
- Latency and throughput:
  - Request to packet: 1 cycle after ic_resp_valid.
  - Peak throughput: one block per 2 cycles with zero-latency ICache; no bubbles beyond that when out_ready=1.

Test Plan:
- Reset then ic_req_ready=1 and 1-cycle response -> first ic_req_addr=0x1eceb000; next address 0x1eceb010; all out_slot_valid=4'b1111; out_pred_target[3]=0x1eceb010.
- Flush with redirect_pc=0x1eceb008 -> ic_req_addr=0x1eceb000; out_slot_valid=4'b1100; next request address 0x1eceb010.
- BTB update upd_pc=0x1eceb004, upd_target=0x1eceb100, taken, then fetch at 0x1eceb000 -> out_pred_taken=4'b0010; out_slot_valid=4'b0011; next request 0x1eceb100. Not-taken update at the same PC, then refetch -> no prediction.
- Flush while in WAIT, old response arrives 3 cycles later -> old data never appears on out_*; the next packet has out_pc=redirect_pc.
- Hold out_ready=0 for 5 cycles with a packet pending -> outputs stable; ic_req_valid=0; on release the next request issues in the same cycle.
- Address wrap: redirect_pc=0xfffffff0 -> the following request address is 0x00000000. Assert rst_n low mid-WAIT -> immediate return to reset values.
